// File: rtl/adc_capture.sv
// adc_capture: dual-channel 14-bit ADC capture with offset-binary conversion, decimation and an FWFT FIFO.
// Define ADC_CAPTURE_AVG_EN to output the window average instead of the window's first sample.

module adc_capture #(
  parameter int unsigned DW         = 14,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SETTLE     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DW-1:0]                 ADC_DA,
  input  logic [DW-1:0]                 ADC_DB,
  input  logic                          ADC_OTR_A,
  input  logic                          ADC_OTR_B,
  output logic                          adc_clk_A,
  output logic                          adc_clk_B,
  output logic                          adc_oe_n,
  input  logic                          enable,
  input  logic                          clear,
  output logic [DW-1:0]                 m_data_a,
  output logic [DW-1:0]                 m_data_b,
  output logic [1:0]                    m_otr,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LD = $clog2(DECIM);
  localparam int unsigned CW = (DECIM > 1) ? LD : 1;
  localparam int unsigned WW = 2 * DW + 2;
  localparam logic [AW:0]   FullLvl = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DLast   = CW'(DECIM - 1);

  typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

  assign adc_clk_A = ~clk;
  assign adc_clk_B = ~clk;

  // Capture pipeline: stage 1 registers the pins, stage 2 converts to two's complement.
  logic [DW-1:0]        s1_a_q, s1_b_q;
  logic [1:0]           s1_otr_q;
  logic signed [DW-1:0] s2_a_q, s2_b_q;
  logic [1:0]           s2_otr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_otr_q <= '0;
      s2_a_q   <= '0;
      s2_b_q   <= '0;
      s2_otr_q <= '0;
    end else begin
      s1_a_q   <= ADC_DA;
      s1_b_q   <= ADC_DB;
      s1_otr_q <= {ADC_OTR_B, ADC_OTR_A};
      s2_a_q   <= {~s1_a_q[DW-1], s1_a_q[DW-2:0]};
      s2_b_q   <= {~s1_b_q[DW-1], s1_b_q[DW-2:0]};
      s2_otr_q <= s1_otr_q;
    end
  end

  state_e        state_q, state_d;
  logic [15:0]   settle_q, settle_d;
  logic [CW-1:0] d_q, d_d;
  logic [1:0]    otr_win_q, otr_win_d, otr_now;
  logic          consume, push, first;
  logic [DW-1:0] word_a, word_b;

`ifdef ADC_CAPTURE_AVG_EN
  localparam int unsigned AccW = DW + LD;
  logic signed [AccW-1:0] acc_a_q, acc_b_q, acc_a_d, acc_b_d, acc_a_now, acc_b_now;
`else
  logic [DW-1:0] hold_a_q, hold_b_q, hold_a_d, hold_b_d;
`endif

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    d_d       = d_q;
    otr_win_d = otr_win_q;
    consume   = 1'b0;
    push      = 1'b0;
    first     = (d_q == '0);
    otr_now   = (first ? 2'b00 : otr_win_q) | s2_otr_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d  = StArm;
          settle_d = '0;
        end
      end
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if ((32'(settle_q) + 32'd1) >= SETTLE) begin
          state_d = StRun;
          d_d     = '0;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
          d_d     = '0;
        end else begin
          consume = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef ADC_CAPTURE_AVG_EN
    acc_a_now = (first ? '0 : acc_a_q) + AccW'(s2_a_q);
    acc_b_now = (first ? '0 : acc_b_q) + AccW'(s2_b_q);
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    // Taking the upper bits is an arithmetic shift: floor of the mean.
    word_a    = acc_a_now[AccW-1:LD];
    word_b    = acc_b_now[AccW-1:LD];
`else
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;
    word_a    = first ? s2_a_q : hold_a_q;
    word_b    = first ? s2_b_q : hold_b_q;
`endif

    if (consume) begin
      otr_win_d = otr_now;
`ifdef ADC_CAPTURE_AVG_EN
      acc_a_d = acc_a_now;
      acc_b_d = acc_b_now;
`else
      hold_a_d = word_a;
      hold_b_d = word_b;
`endif
      if (d_q == DLast) begin
        push = 1'b1;
        d_d  = '0;
      end else begin
        d_d = d_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      d_q       <= '0;
      otr_win_q <= '0;
`ifdef ADC_CAPTURE_AVG_EN
      acc_a_q   <= '0;
      acc_b_q   <= '0;
`else
      hold_a_q  <= '0;
      hold_b_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      d_q       <= d_d;
      otr_win_q <= otr_win_d;
`ifdef ADC_CAPTURE_AVG_EN
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
`else
      hold_a_q  <= hold_a_d;
      hold_b_q  <= hold_b_d;
`endif
    end
  end

  assign adc_oe_n = (state_q == StIdle);

  // Output FIFO: extra pointer bit distinguishes full from empty.
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q, level;
  logic          full, empty, pop, do_push, drop;
  logic          ovf_q;
  logic [WW-1:0] rd_word;

  assign level   = wr_q - rd_q;
  assign full    = (level == FullLvl);
  assign empty   = (level == '0);
  assign pop     = !empty && m_ready;
  assign do_push = push && !clear && (!full || pop);
  assign drop    = push && !clear && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW + 1)'(1);
      if (pop)     rd_q <= rd_q + (AW + 1)'(1);
      if (drop)    ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= {otr_now, word_b, word_a};
  end

  assign rd_word    = mem[rd_q[AW-1:0]];
  assign m_valid    = !empty;
  assign m_data_a   = m_valid ? rd_word[DW-1:0] : '0;
  assign m_data_b   = m_valid ? rd_word[2*DW-1:DW] : '0;
  assign m_otr      = m_valid ? rd_word[WW-1:2*DW] : '0;
  assign overflow   = ovf_q;
  assign fifo_level = level;

endmodule

// File: tb/tb_adc_capture.sv
// Randomized bench for adc_capture against a queue-based reference model of the capture path.
// Honours ADC_CAPTURE_AVG_EN the same way as the design.

module tb_adc_capture;

  localparam int DW     = 14;
  localparam int DECIM  = 4;
  localparam int FD     = 16;
  localparam int SETTLE = 8;
  localparam int LW     = $clog2(FD) + 1;
`ifdef ADC_CAPTURE_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic          clk, rst_n;
  logic [DW-1:0] adc_da, adc_db;
  logic          otr_a, otr_b, enable, clear, m_ready;
  logic          adc_clk_a, adc_clk_b, adc_oe_n, m_valid, overflow;
  logic [DW-1:0] m_data_a, m_data_b;
  logic [1:0]    m_otr;
  logic [LW-1:0] fifo_level;

  adc_capture #(
    .DW         (DW),
    .DECIM      (DECIM),
    .FIFO_DEPTH (FD),
    .SETTLE     (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ADC_DA     (adc_da),
    .ADC_DB     (adc_db),
    .ADC_OTR_A  (otr_a),
    .ADC_OTR_B  (otr_b),
    .adc_clk_A  (adc_clk_a),
    .adc_clk_B  (adc_clk_b),
    .adc_oe_n   (adc_oe_n),
    .enable     (enable),
    .clear      (clear),
    .m_data_a   (m_data_a),
    .m_data_b   (m_data_b),
    .m_otr      (m_otr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: words awaiting drain, pipeline history and the current window.
  typedef struct {int a; int b; int otr;} word_t;
  word_t q[$];
  int    win_a[$], win_b[$];
  int    win_o, age, h1_a, h1_b, h1_o, h2_a, h2_b, h2_o;
  bit    ovf;

  function automatic int to_val(input int raw);
    return raw - 8192;
  endfunction

  function automatic int floor_div(input int s, input int d);
    int r;
    r = s % d;
    if (r < 0) r += d;
    return (s - r) / d;
  endfunction

  task automatic model_reset();
    q.delete(); win_a.delete(); win_b.delete();
    win_o = 0; age = 0; ovf = 0;
    h1_a = 8192; h1_b = 8192; h1_o = 0; h2_a = 8192; h2_b = 8192; h2_o = 0;
  endtask

  task automatic model_edge();
    bit    pop, push, full_drop;
    word_t w;
    int    sa, sb;
    pop  = (q.size() > 0) && m_ready;
    push = 0;
    w    = '{0, 0, 0};
    if (enable && age > SETTLE) begin
      win_a.push_back(to_val(h2_a));
      win_b.push_back(to_val(h2_b));
      win_o |= h2_o;
      if (win_a.size() == DECIM) begin
        if (AVG) begin
          sa = 0; sb = 0;
          foreach (win_a[i]) begin sa += win_a[i]; sb += win_b[i]; end
          w.a = floor_div(sa, DECIM) & 16'h3FFF;
          w.b = floor_div(sb, DECIM) & 16'h3FFF;
        end else begin
          w.a = win_a[0] & 16'h3FFF;
          w.b = win_b[0] & 16'h3FFF;
        end
        w.otr = win_o;
        push  = 1;
        win_a.delete(); win_b.delete(); win_o = 0;
      end
    end else begin
      win_a.delete(); win_b.delete(); win_o = 0;
    end
    if (clear) begin
      q.delete();
      ovf = 0;
    end else begin
      full_drop = push && (q.size() == FD) && !pop;
      if (pop) void'(q.pop_front());
      if (push && !full_drop) q.push_back(w);
      if (full_drop) ovf = 1;
    end
    age  = enable ? age + 1 : 0;
    h2_a = h1_a; h2_b = h1_b; h2_o = h1_o;
    h1_a = int'(adc_da); h1_b = int'(adc_db); h1_o = int'({otr_b, otr_a});
  endtask

  // One clock: model consumes the inputs held across the edge, outputs checked 1ns later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("m_valid", m_valid, q.size() > 0);
    check("fifo_level", fifo_level, q.size());
    check("overflow", overflow, ovf);
    check("adc_oe_n", adc_oe_n, age == 0);
    check("adc_clk", {adc_clk_b, adc_clk_a}, 2'b00);
    if (q.size() > 0) begin
      check("m_data_a", m_data_a, q[0].a);
      check("m_data_b", m_data_b, q[0].b);
      check("m_otr", m_otr, q[0].otr);
    end
  endtask

  function automatic logic [DW-1:0] rand_sample();
    logic [DW-1:0] specials [4];
    specials = '{14'h2000, 14'h3FFF, 14'h0000, 14'h1FFF};
    if ($urandom_range(3) == 0) return specials[$urandom_range(3)];
    return DW'($urandom);
  endfunction

  task automatic rand_inputs(input int otr_odds);
    adc_da = rand_sample();
    adc_db = rand_sample();
    otr_a  = ($urandom_range(otr_odds) == 0);
    otr_b  = ($urandom_range(otr_odds) == 0);
  endtask

  initial begin
    logic [DW-1:0] t2_tbl [4];
    int            ready_pct;
    bit            reached;
    t2_tbl = '{14'h2001, 14'h2002, 14'h2003, 14'h2006};

    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; m_ready = 1'b0;
    adc_da = '0; adc_db = '0; otr_a = 1'b0; otr_b = 1'b0;
    model_reset();
    #12;
    check("rst_valid", m_valid, 0);
    check("rst_data_a", m_data_a, 0);
    check("rst_data_b", m_data_b, 0);
    check("rst_otr", m_otr, 0);
    check("rst_ovf", overflow, 0);
    check("rst_level", fifo_level, 0);
    check("rst_oe_n", adc_oe_n, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Window of 0x2001,0x2002,0x2003,0x2006 lands exactly on the first RUN window.
    enable = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      rand_inputs(1000);
      otr_a = 1'b0; otr_b = 1'b0;
      if (i >= 7 && i <= 10) adc_da = t2_tbl[i - 7];
      step();
    end
    check("t2_word", m_data_a, AVG ? 3 : 1);

    // Fill past capacity with the sink stalled.
    for (int i = 0; i < 80; i++) begin
      rand_inputs(30);
      step();
    end
    check("t3_level", fifo_level, FD);
    check("t3_ovf", overflow, 1);
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("t3_drained", m_valid, 0);
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin rand_inputs(30); step(); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t3_clr_valid", m_valid, 0);
    check("t3_clr_ovf", overflow, 0);

    // Enable dropped mid-window with the sink draining.
    m_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin rand_inputs(30); step(); end
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin rand_inputs(30); step(); end
    check("t6_empty", m_valid, 0);
    check("t6_oe_n", adc_oe_n, 1);

    // Random traffic.
    ready_pct = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) ready_pct = $urandom_range(100);
      rand_inputs(20);
      if ($urandom_range(59) == 0) enable = ~enable;
      m_ready = ($urandom_range(99) < ready_pct);
      clear   = ($urandom_range(149) == 0);
      step();
    end
    clear = 1'b0;

    // Asynchronous reset while running with five words buffered.
    clear = 1'b1; step(); clear = 1'b0;
    enable = 1'b1; m_ready = 1'b0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      rand_inputs(20);
      step();
      reached = (q.size() == 5);
    end
    check("t5_reach", reached, 1);
    rst_n = 1'b0;
    #1;
    check("t5_valid", m_valid, 0);
    check("t5_level", fifo_level, 0);
    check("t5_oe_n", adc_oe_n, 1);
    check("t5_ovf", overflow, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin rand_inputs(20); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
